// File: rtl/reg_seq_pkg.sv
// ============================================================================
// Module      : reg_seq_pkg
// Description : Shared types for the register sequencing engine: command
//               table entries, error codes, FSM states and REG_BUS structs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_seq_pkg;

    localparam int unsigned c_REG_AW = 32;
    localparam int unsigned c_REG_DW = 32;

    typedef enum logic [1:0] {
        OP_END   = 2'd0,
        OP_WRITE = 2'd1,
        OP_POLL  = 2'd2,
        OP_DELAY = 2'd3
    } reg_seq_op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BUS     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } reg_seq_err_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_BUS    = 3'd2,
        ST_GAP    = 3'd3,
        ST_DELAY  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } reg_seq_state_e;

    typedef struct packed {
        reg_seq_op_e           op;
        logic [c_REG_AW-1:0]   addr;
        logic [c_REG_DW-1:0]   data;
        logic [c_REG_DW-1:0]   mask;
        logic [3:0]            wstrb;
    } reg_seq_cmd_t;

    typedef struct packed {
        logic [c_REG_AW-1:0]   addr;
        logic                  write;
        logic [c_REG_DW-1:0]   wdata;
        logic [3:0]            wstrb;
        logic                  valid;
    } reg_bus_req_t;

    typedef struct packed {
        logic [c_REG_DW-1:0]   rdata;
        logic                  error;
        logic                  ready;
    } reg_bus_rsp_t;

endpackage

`default_nettype wire

// File: rtl/reg_seq_engine.sv
// ============================================================================
// Module      : reg_seq_engine
// Description : Walks a command table issuing REG_BUS writes, polls and
//               delays, reporting done / error with the failing index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_seq_engine
    import reg_seq_pkg::*;
#(
    parameter int unsigned NumCmds     = 16,
    parameter int unsigned PollTimeout = 1024,
    parameter int unsigned GapCycles   = 4,
    parameter type         reg_req_t   = reg_bus_req_t,
    parameter type         reg_rsp_t   = reg_bus_rsp_t
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  reg_seq_cmd_t [NumCmds-1:0]         cmd_i,
    output reg_req_t                           reg_req_o,
    input  reg_rsp_t                           reg_rsp_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               error_o,
    output logic [1:0]                         err_code_o,
    output logic [$clog2(NumCmds+1)-1:0]       cmd_idx_o
);

    localparam int unsigned IdxW    = $clog2(NumCmds + 1);
    localparam int unsigned RdCntW  = $clog2(PollTimeout + 1);
    localparam int unsigned GapW    = $clog2(GapCycles + 2);
    localparam int unsigned GapLast = (GapCycles > 0) ? GapCycles - 1 : 0;

    reg_seq_state_e        state_q, state_d;
    logic [IdxW-1:0]       cmd_idx_q, cmd_idx_d;
    logic [RdCntW-1:0]     read_cnt_q, read_cnt_d;
    logic [31:0]           delay_cnt_q, delay_cnt_d;
    logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
    reg_seq_err_e          err_code_q, err_code_d;
    logic                  abort_pend_q, abort_pend_d;

    reg_seq_cmd_t          cur_cmd;
    logic [IdxW-1:0]       idx_inc;
    logic [RdCntW-1:0]     rd_inc;
    logic                  poll_match;

    // Explicit compare loop keeps the out-of-table index (NumCmds) harmless.
    always_comb begin
        cur_cmd = '0;
        for (int unsigned i = 0; i < NumCmds; i++) begin
            if (cmd_idx_q == IdxW'(i)) begin
                cur_cmd = cmd_i[i];
            end
        end
    end

    always_comb begin
        idx_inc    = (cmd_idx_q == IdxW'(NumCmds)) ? cmd_idx_q : cmd_idx_q + 1'b1;
        rd_inc     = (read_cnt_q == '1) ? read_cnt_q : read_cnt_q + 1'b1;
        poll_match = ((reg_rsp_i.rdata ^ cur_cmd.data) & cur_cmd.mask) == '0;
    end

    always_comb begin
        state_d      = state_q;
        cmd_idx_d    = cmd_idx_q;
        read_cnt_d   = read_cnt_q;
        delay_cnt_d  = delay_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        err_code_d   = err_code_q;
        abort_pend_d = abort_pend_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    state_d      = ST_DECODE;
                    cmd_idx_d    = '0;
                    err_code_d   = ERR_NONE;
                    abort_pend_d = 1'b0;
                end
            end
            ST_DECODE: begin
                if (abort_i) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_ABORT;
                end else if (cmd_idx_q == IdxW'(NumCmds)) begin
                    state_d = ST_DONE;
                end else begin
                    case (cur_cmd.op)
                        OP_WRITE, OP_POLL: begin
                            state_d    = ST_BUS;
                            read_cnt_d = '0;
                        end
                        OP_DELAY: begin
                            if (cur_cmd.data == '0) begin
                                cmd_idx_d = idx_inc;
                            end else begin
                                state_d     = ST_DELAY;
                                delay_cnt_d = cur_cmd.data;
                            end
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_BUS: begin
                if (reg_rsp_i.ready) begin
                    abort_pend_d = 1'b0;
                    // A pending or simultaneous abort overrides whatever came back.
                    if (abort_i || abort_pend_q) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_ABORT;
                    end else if (reg_rsp_i.error) begin
                        state_d    = ST_ERROR;
                        err_code_d = ERR_BUS;
                    end else if (cur_cmd.op == OP_WRITE || poll_match) begin
                        state_d   = ST_DECODE;
                        cmd_idx_d = idx_inc;
                    end else begin
                        read_cnt_d = rd_inc;
                        gap_cnt_d  = '0;
                        if (rd_inc >= RdCntW'(PollTimeout)) begin
                            state_d    = ST_ERROR;
                            err_code_d = ERR_TIMEOUT;
                        end else if (GapCycles == 0) begin
                            state_d = ST_BUS;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end else if (abort_i) begin
                    abort_pend_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (abort_i) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_ABORT;
                end else if (gap_cnt_q == GapW'(GapLast)) begin
                    state_d = ST_BUS;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_DELAY: begin
                if (abort_i) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_ABORT;
                end else if (delay_cnt_q <= 32'd1) begin
                    delay_cnt_d = '0;
                    state_d     = ST_DECODE;
                    cmd_idx_d   = idx_inc;
                end else begin
                    delay_cnt_d = delay_cnt_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cmd_idx_q    <= '0;
            read_cnt_q   <= '0;
            delay_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            err_code_q   <= ERR_NONE;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_idx_q    <= cmd_idx_d;
            read_cnt_q   <= read_cnt_d;
            delay_cnt_q  <= delay_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            err_code_q   <= err_code_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Request decoded from state so an asynchronous reset drops valid at once.
    always_comb begin
        reg_req_o = '0;
        if (state_q == ST_BUS) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = cur_cmd.addr;
            reg_req_o.write = (cur_cmd.op == OP_WRITE);
            if (cur_cmd.op == OP_WRITE) begin
                reg_req_o.wdata = cur_cmd.data;
                reg_req_o.wstrb = cur_cmd.wstrb;
            end
        end
    end

    always_comb begin
        busy_o     = (state_q == ST_DECODE) || (state_q == ST_BUS) ||
                     (state_q == ST_GAP)    || (state_q == ST_DELAY);
        done_o     = (state_q == ST_DONE);
        error_o    = (state_q == ST_ERROR);
        err_code_o = err_code_q;
        cmd_idx_o  = cmd_idx_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_seq_engine.sv
// ============================================================================
// Module      : tb_reg_seq_engine
// Description : Directed bench for reg_seq_engine with a scripted REG_BUS slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_seq_engine;
    import reg_seq_pkg::*;

    localparam int unsigned c_NC = 8;
    localparam int unsigned c_PT = 8;
    localparam int unsigned c_GC = 4;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    reg_seq_cmd_t [c_NC-1:0] cmd;
    reg_bus_req_t            req;
    reg_bus_rsp_t            rsp;
    logic                    busy, done, error;
    logic [1:0]              err_code;
    logic [3:0]              cmd_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_seq_engine #(
        .NumCmds     (c_NC),
        .PollTimeout (c_PT),
        .GapCycles   (c_GC)
    ) u_dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .cmd_i      (cmd),
        .reg_req_o  (req),
        .reg_rsp_i  (rsp),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .err_code_o (err_code),
        .cmd_idx_o  (cmd_idx)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          exp_wait;
    } wr_vec_t;

    typedef struct {
        logic [31:0] rdata;
        int          exp_wait;
    } poll_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic reg_seq_cmd_t mk(input reg_seq_op_e op, input logic [31:0] a,
                                        input logic [31:0] d, input logic [31:0] m);
        reg_seq_cmd_t c;
        c.op = op; c.addr = a; c.data = d; c.mask = m; c.wstrb = 4'hF;
        return c;
    endfunction

    task automatic clear_cmds();
        for (int i = 0; i < int'(c_NC); i++) cmd[i] = '0;
    endtask

    task automatic start_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_clears_err", {30'd0, err_code}, 32'd0);
    endtask

    // Waits for a request, optionally stalls / aborts, then answers it.
    task automatic serve(input int lat, input logic err, input logic [31:0] rdata,
                         input logic do_abort, output reg_bus_req_t got,
                         output int waited, output logic stable);
        waited = 0;
        stable = 1'b1;
        while (!req.valid && waited < 200) begin
            tick();
            waited++;
        end
        got = req;
        chk("valid_seen", {31'd0, req.valid}, 32'd1);
        if (!req.valid) return;
        abort = do_abort;
        repeat (lat) begin
            tick();
            abort = 1'b0;
            if (req !== got) stable = 1'b0;
        end
        rsp.ready = 1'b1;
        rsp.error = err;
        rsp.rdata = rdata;
        tick();
        abort = 1'b0;
        rsp   = '0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("terminated", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reg_bus_req_t got;
        int           waited;
        logic         stable;
        logic         seen;
        wr_vec_t      wv [3];
        poll_vec_t    pv [3];

        wv[0] = '{32'h2000_0000, 32'h9800_1032, 2, 1};
        wv[1] = '{32'h2000_0004, 32'h0000_2070, 2, 1};
        wv[2] = '{32'h2000_003C, 32'h0000_0001, 2, 1};
        // First read follows the DECODE cycle, later reads follow a full gap.
        pv[0] = '{32'h0000_0000, 1};
        pv[1] = '{32'h0000_0000, int'(c_GC)};
        pv[2] = '{32'h0000_0001, int'(c_GC)};

        rsp = '0;
        clear_cmds();
        tick();
        chk("rst_busy",     {31'd0, busy},      32'd0);
        chk("rst_done",     {31'd0, done},      32'd0);
        chk("rst_error",    {31'd0, error},     32'd0);
        chk("rst_err_code", {30'd0, err_code},  32'd0);
        chk("rst_cmd_idx",  {28'd0, cmd_idx},   32'd0);
        chk("rst_valid",    {31'd0, req.valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Three writes then END.
        clear_cmds();
        for (int i = 0; i < 3; i++) cmd[i] = mk(OP_WRITE, wv[i].addr, wv[i].data, 32'h0);
        start_seq();
        for (int i = 0; i < 3; i++) begin
            serve(wv[i].lat, 1'b0, 32'h0, 1'b0, got, waited, stable);
            chk("wr_addr",   got.addr,              wv[i].addr);
            chk("wr_wdata",  got.wdata,             wv[i].data);
            chk("wr_write",  {31'd0, got.write},    32'd1);
            chk("wr_wstrb",  {28'd0, got.wstrb},    32'hF);
            chk("wr_stable", {31'd0, stable},       32'd1);
            chk("wr_wait",   waited,                wv[i].exp_wait);
            chk("wr_valid_drop", {31'd0, req.valid}, 32'd0);
        end
        wait_end();
        chk("wr_done",    {31'd0, done},     32'd1);
        chk("wr_error",   {31'd0, error},    32'd0);
        chk("wr_cmd_idx", {28'd0, cmd_idx},  32'd3);
        seen = 1'b0;
        repeat (5) begin tick(); if (req.valid) seen = 1'b1; end
        chk("wr_no_extra", {31'd0, seen}, 32'd0);

        // POLL that matches on the third read.
        clear_cmds();
        cmd[0] = mk(OP_POLL, 32'h2000_0048, 32'h1, 32'h1);
        start_seq();
        for (int i = 0; i < 3; i++) begin
            serve(0, 1'b0, pv[i].rdata, 1'b0, got, waited, stable);
            chk("poll_addr",  got.addr,           32'h2000_0048);
            chk("poll_write", {31'd0, got.write}, 32'd0);
            chk("poll_gap",   waited,             pv[i].exp_wait);
        end
        wait_end();
        chk("poll_done",    {31'd0, done},    32'd1);
        chk("poll_cmd_idx", {28'd0, cmd_idx}, 32'd1);

        // POLL that never matches, behind a WRITE.
        clear_cmds();
        cmd[0] = mk(OP_WRITE, 32'h2000_0010, 32'h55, 32'h0);
        cmd[1] = mk(OP_POLL,  32'h2000_0048, 32'h5A, 32'hFF);
        start_seq();
        serve(0, 1'b0, 32'h0, 1'b0, got, waited, stable);
        for (int r = 0; r < int'(c_PT); r++) begin
            serve(1, 1'b0, 32'h0, 1'b0, got, waited, stable);
            chk("to_gap", waited, (r == 0) ? 1 : int'(c_GC));
        end
        chk("to_error",    {31'd0, error},    32'd1);
        chk("to_err_code", {30'd0, err_code}, 32'd2);
        chk("to_cmd_idx",  {28'd0, cmd_idx},  32'd1);
        chk("to_busy",     {31'd0, busy},     32'd0);

        // Second WRITE answered with a bus error.
        clear_cmds();
        for (int i = 0; i < 3; i++) cmd[i] = mk(OP_WRITE, wv[i].addr, wv[i].data, 32'h0);
        start_seq();
        serve(1, 1'b0, 32'h0, 1'b0, got, waited, stable);
        serve(1, 1'b1, 32'h0, 1'b0, got, waited, stable);
        chk("berr_error",    {31'd0, error},    32'd1);
        chk("berr_err_code", {30'd0, err_code}, 32'd1);
        chk("berr_cmd_idx",  {28'd0, cmd_idx},  32'd1);
        seen = 1'b0;
        repeat (20) begin tick(); if (req.valid) seen = 1'b1; end
        chk("berr_no_req", {31'd0, seen}, 32'd0);

        // Abort while the slave stalls for 10 cycles.
        clear_cmds();
        cmd[0] = mk(OP_WRITE, 32'h2000_0020, 32'hA5, 32'h0);
        start_seq();
        serve(10, 1'b0, 32'h0, 1'b1, got, waited, stable);
        chk("abt_held",     {31'd0, stable},   32'd1);
        chk("abt_error",    {31'd0, error},    32'd1);
        chk("abt_done",     {31'd0, done},     32'd0);
        chk("abt_err_code", {30'd0, err_code}, 32'd3);
        chk("abt_cmd_idx",  {28'd0, cmd_idx},  32'd0);

        // Abort in the same cycle as a matching poll response wins.
        clear_cmds();
        cmd[0] = mk(OP_POLL, 32'h2000_0048, 32'h1, 32'h1);
        start_seq();
        serve(0, 1'b0, 32'h1, 1'b1, got, waited, stable);
        chk("abt_prio_err_code", {30'd0, err_code}, 32'd3);
        chk("abt_prio_done",     {31'd0, done},     32'd0);

        // Abort during a long DELAY takes effect next cycle.
        clear_cmds();
        cmd[0] = mk(OP_DELAY, 32'h0, 32'd100, 32'h0);
        start_seq();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_dly_error",    {31'd0, error},    32'd1);
        chk("abt_dly_err_code", {30'd0, err_code}, 32'd3);

        // DELAY 5 between two writes: 1 decode + 5 delay cycles for the
        // DELAY command, then the decode of the next WRITE before its valid.
        clear_cmds();
        cmd[0] = mk(OP_WRITE, 32'h2000_0000, 32'h1, 32'h0);
        cmd[1] = mk(OP_DELAY, 32'h0, 32'd5, 32'h0);
        cmd[2] = mk(OP_WRITE, 32'h2000_0004, 32'h2, 32'h0);
        start_seq();
        serve(0, 1'b0, 32'h0, 1'b0, got, waited, stable);
        serve(0, 1'b0, 32'h0, 1'b0, got, waited, stable);
        chk("dly_gap",  waited,   32'd7);
        chk("dly_addr", got.addr, 32'h2000_0004);
        wait_end();
        chk("dly_done", {31'd0, done}, 32'd1);

        // Reset asserted while a request is outstanding.
        clear_cmds();
        cmd[0] = mk(OP_WRITE, 32'h2000_0030, 32'h3, 32'h0);
        start_seq();
        tick();
        chk("mid_valid_pre", {31'd0, req.valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid",    {31'd0, req.valid}, 32'd0);
        chk("mid_addr",     req.addr,           32'd0);
        chk("mid_busy",     {31'd0, busy},      32'd0);
        chk("mid_done",     {31'd0, done},      32'd0);
        chk("mid_error",    {31'd0, error},     32'd0);
        chk("mid_err_code", {30'd0, err_code},  32'd0);
        chk("mid_cmd_idx",  {28'd0, cmd_idx},   32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
